// File: rtl/set_pattern_driver.sv
// On-chip initiator for the SET candidate-counting interface: walks a pattern ROM,
// issues each (central, radius) to SET and checks the returned candidate.
module set_pattern_driver #(
  parameter int unsigned NUM_PAT   = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ERR_LIMIT = 10,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [23:0]       rom_central,
  input  logic [11:0]       rom_radius,
  input  logic [7:0]        rom_expected,
  output logic              set_en,
  output logic [23:0]       set_central,
  output logic [11:0]       set_radius,
  output logic [1:0]        set_mode,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [7:0]        set_candidate,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [6:0]        err_cnt,
  output logic [ADDR_W-1:0] first_fail
);

  localparam int unsigned       TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PAT - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [6:0]        ERR_LIM  = 7'(ERR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_IDLE,
    S_ISSUE,
    S_WAIT_VALID,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_exp;
  logic [7:0]        r_cand;
  logic [TW-1:0]     r_tmo;
  logic [6:0]        r_err;
  logic              r_aborted;
  logic [ADDR_W-1:0] r_first;
  logic [23:0]       r_central;
  logic [11:0]       r_radius;
  logic [1:0]        r_mode;

  logic              w_mismatch;
  logic [6:0]        w_err_sat;
  logic              w_limit;
  logic              w_tmo_last;

  assign w_mismatch = (r_cand != r_exp);
  assign w_err_sat  = (r_err == 7'h7F) ? r_err : r_err + 7'd1;
  assign w_limit    = (w_err_sat >= ERR_LIM);
  assign w_tmo_last = (r_tmo == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // LOAD skips WAIT_IDLE when SET is already idle so an unstalled pattern
  // reaches ISSUE in three cycles.
  always_comb begin
    w_next  = r_state;
    set_en  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    case (r_state)
      S_IDLE:       if (start) w_next = S_FETCH;
      S_FETCH: begin
        running = 1'b1;
        w_next  = S_LOAD;
      end
      S_LOAD: begin
        running = 1'b1;
        w_next  = set_busy ? S_WAIT_IDLE : S_ISSUE;
      end
      S_WAIT_IDLE: begin
        running = 1'b1;
        if (!set_busy) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        running = 1'b1;
        set_en  = 1'b1;
        w_next  = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        running = 1'b1;
        if (set_valid)       w_next = S_CHECK;
        else if (w_tmo_last) w_next = S_DONE;
      end
      S_CHECK: begin
        running = 1'b1;
        if (w_mismatch && w_limit) w_next = S_DONE;
        else if (r_idx == LAST_IDX) w_next = S_DONE;
        else                        w_next = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_err == 7'd0) && !r_aborted;
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_exp     <= '0;
      r_cand    <= '0;
      r_tmo     <= '0;
      r_err     <= '0;
      r_aborted <= 1'b0;
      r_first   <= '0;
      r_central <= '0;
      r_radius  <= '0;
      r_mode    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode    <= mode_sel;
            r_err     <= '0;
            r_first   <= '0;
            r_aborted <= 1'b0;
            r_idx     <= '0;
          end
        end
        S_LOAD: begin
          r_central <= rom_central;
          r_radius  <= rom_radius;
          r_exp     <= rom_expected;
        end
        S_ISSUE: r_tmo <= '0;
        S_WAIT_VALID: begin
          if (set_valid) begin
            r_cand <= set_candidate;
          end else if (w_tmo_last) begin
            r_err     <= w_err_sat;
            r_aborted <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= w_err_sat;
            if (r_err == 7'd0) r_first <= r_idx;
            if (w_limit)       r_aborted <= 1'b1;
          end
          if (!(w_mismatch && w_limit) && (r_idx != LAST_IDX))
            r_idx <= r_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign pat_addr    = r_idx;
  assign set_central = r_central;
  assign set_radius  = r_radius;
  assign set_mode    = r_mode;
  assign aborted     = r_aborted;
  assign err_cnt     = r_err;
  assign first_fail  = r_first;

endmodule

// File: tb/tb_set_pattern_driver.sv
// Directed bench for set_pattern_driver: synchronous pattern ROM plus a
// fixed 5-cycle-latency SET model with busy-force and dropped-valid knobs.
module tb_set_pattern_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [5:0]  pat_addr;
  logic [23:0] rom_central;
  logic [11:0] rom_radius;
  logic [7:0]  rom_expected;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        running, done, pass, aborted;
  logic [6:0]  err_cnt;
  logic [5:0]  first_fail;

  int total = 0;
  int bad   = 0;

  logic [23:0] rom_c [64];
  logic [11:0] rom_r [64];
  logic [7:0]  rom_e [64];

  logic        busy_force = 1'b0;
  int          drop_idx   = -1;
  logic        m_active;
  logic        m_drop;
  logic [2:0]  m_cnt;
  logic [7:0]  m_res;
  int          en_cnt = 0;
  int          en_busy_viol = 0;
  int          en_double = 0;
  logic        prev_en = 1'b0;

  always #5 clk = ~clk;

  set_pattern_driver #(
    .NUM_PAT(64), .ADDR_W(6), .ERR_LIMIT(10), .TIMEOUT(4095)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
    .pat_addr(pat_addr), .rom_central(rom_central), .rom_radius(rom_radius),
    .rom_expected(rom_expected), .set_en(set_en), .set_central(set_central),
    .set_radius(set_radius), .set_mode(set_mode), .set_busy(set_busy),
    .set_valid(set_valid), .set_candidate(set_candidate), .running(running),
    .done(done), .pass(pass), .aborted(aborted), .err_cnt(err_cnt),
    .first_fail(first_fail)
  );

  function automatic logic [7:0] set_fn(input logic [23:0] c, input logic [11:0] r,
                                        input logic [1:0] m);
    return c[7:0] ^ c[15:8] ^ c[23:16] ^ r[7:0] ^ {r[11:8], 2'b00, m};
  endfunction

  always @(posedge clk) begin
    rom_central  <= rom_c[pat_addr];
    rom_radius   <= rom_r[pat_addr];
    rom_expected <= rom_e[pat_addr];
  end

  assign set_busy = m_active | busy_force;

  always @(posedge clk) begin
    if (rst) begin
      m_active      <= 1'b0;
      m_drop        <= 1'b0;
      m_cnt         <= '0;
      m_res         <= '0;
      set_valid     <= 1'b0;
      set_candidate <= '0;
    end else begin
      set_valid <= 1'b0;
      if (set_en) begin
        m_active <= 1'b1;
        m_cnt    <= '0;
        m_res    <= set_fn(set_central, set_radius, set_mode);
        m_drop   <= (int'(pat_addr) == drop_idx);
      end else if (m_active) begin
        if (m_cnt == 3'd3) begin
          m_active <= 1'b0;
          if (!m_drop) begin
            set_valid     <= 1'b1;
            set_candidate <= m_res;
          end
        end else begin
          m_cnt <= m_cnt + 3'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    prev_en <= set_en;
    if (set_en) en_cnt <= en_cnt + 1;
    if (set_en && busy_force) en_busy_viol <= en_busy_viol + 1;
    if (set_en && prev_en) en_double <= en_double + 1;
  end

  task automatic setup_rom(input logic [1:0] m);
    for (int i = 0; i < 64; i++) begin
      rom_c[i] = {8'(i * 7 + 1), 8'(i) ^ 8'h5A, 8'(i * 3)};
      rom_r[i] = 12'(i * 37 + 5);
      rom_e[i] = set_fn(rom_c[i], rom_r[i], m);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    mode_sel = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (set_en !== 1'b0)      begin bad++; $display("FAIL rst_set_en got=%b want=0", set_en); end
    total++; if (running !== 1'b0)     begin bad++; $display("FAIL rst_running got=%b want=0", running); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (pass !== 1'b0)        begin bad++; $display("FAIL rst_pass got=%b want=0", pass); end
    total++; if (aborted !== 1'b0)     begin bad++; $display("FAIL rst_aborted got=%b want=0", aborted); end
    total++; if (err_cnt !== 7'd0)     begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
    total++; if (pat_addr !== 6'd0)    begin bad++; $display("FAIL rst_pat_addr got=%0d want=0", pat_addr); end
    total++; if (first_fail !== 6'd0)  begin bad++; $display("FAIL rst_first_fail got=%0d want=0", first_fail); end
    total++; if (set_central !== 24'd0 || set_radius !== 12'd0 || set_mode !== 2'd0) begin
      bad++; $display("FAIL rst_set_bus got=%h/%h/%b want=0", set_central, set_radius, set_mode);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int base;
    setup_rom(2'b00);
    base = en_cnt;
    do_start(2'b00);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL basic_running got=%b want=1", running); end
    @(negedge clk);
    total++; if (set_en !== 1'b0) begin bad++; $display("FAIL basic_en_early got=%b want=0", set_en); end
    @(negedge clk);
    total++; if (set_en !== 1'b1) begin bad++; $display("FAIL basic_en_latency got=%b want=1", set_en); end
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=0 want=1"); end
    total++; if (en_cnt - base != 64) begin bad++; $display("FAIL basic_issued got=%0d want=64", en_cnt - base); end
    total++; if (pass !== 1'b1 || err_cnt !== 7'd0 || aborted !== 1'b0) begin
      bad++; $display("FAIL basic_result got=pass%b err%0d ab%b want=pass1 err0 ab0", pass, err_cnt, aborted);
    end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL basic_running_end got=%b want=0", running); end
  endtask

  task automatic test_mismatch();
    bit ok;
    int base;
    setup_rom(2'b01);
    rom_e[3]  = rom_e[3] ^ 8'hFF;
    rom_e[40] = rom_e[40] ^ 8'h01;
    base = en_cnt;
    do_start(2'b01);
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL mm_done_timeout got=0 want=1"); end
    total++; if (err_cnt !== 7'd2) begin bad++; $display("FAIL mm_err_cnt got=%0d want=2", err_cnt); end
    total++; if (first_fail !== 6'd3) begin bad++; $display("FAIL mm_first_fail got=%0d want=3", first_fail); end
    total++; if (pass !== 1'b0 || aborted !== 1'b0) begin
      bad++; $display("FAIL mm_flags got=pass%b ab%b want=pass0 ab0", pass, aborted);
    end
    total++; if (en_cnt - base != 64) begin bad++; $display("FAIL mm_issued got=%0d want=64", en_cnt - base); end
  endtask

  task automatic test_abort();
    bit ok;
    int base;
    setup_rom(2'b10);
    for (int i = 5; i < 17; i++) rom_e[i] = rom_e[i] ^ 8'h80;
    base = en_cnt;
    do_start(2'b10);
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL ab_done_timeout got=0 want=1"); end
    total++; if (aborted !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL ab_flags got=ab%b pass%b want=ab1 pass0", aborted, pass);
    end
    total++; if (err_cnt !== 7'd10) begin bad++; $display("FAIL ab_err_cnt got=%0d want=10", err_cnt); end
    total++; if (first_fail !== 6'd5) begin bad++; $display("FAIL ab_first_fail got=%0d want=5", first_fail); end
    total++; if (en_cnt - base != 15) begin bad++; $display("FAIL ab_issued got=%0d want=15", en_cnt - base); end
    repeat (20) @(negedge clk);
    total++; if (en_cnt - base != 15) begin bad++; $display("FAIL ab_no_more_en got=%0d want=15", en_cnt - base); end
  endtask

  task automatic test_timeout();
    bit ok;
    int base, last_en, done_at;
    setup_rom(2'b00);
    drop_idx = 7;
    base = en_cnt;
    last_en = -1;
    done_at = -1;
    ok = 1'b0;
    do_start(2'b00);
    for (int k = 0; k < 6000; k++) begin
      if (set_en) last_en = k;
      if (done) begin
        ok = 1'b1;
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    drop_idx = -1;
    total++; if (!ok) begin bad++; $display("FAIL to_done_timeout got=0 want=1"); end
    total++; if (done_at - last_en != 4096) begin
      bad++; $display("FAIL to_wait_len got=%0d want=4096", done_at - last_en);
    end
    total++; if (err_cnt !== 7'd1 || aborted !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL to_result got=err%0d ab%b pass%b want=err1 ab1 pass0", err_cnt, aborted, pass);
    end
    total++; if (en_cnt - base != 8) begin bad++; $display("FAIL to_issued got=%0d want=8", en_cnt - base); end
  endtask

  task automatic test_busy_reset();
    bit ok, got;
    int base;
    setup_rom(2'b11);
    busy_force = 1'b1;
    base = en_cnt;
    do_start(2'b11);
    repeat (20) @(negedge clk);
    total++; if (en_cnt - base != 0 || en_busy_viol != 0) begin
      bad++; $display("FAIL busy_no_en got=%0d/%0d want=0/0", en_cnt - base, en_busy_viol);
    end
    total++; if (running !== 1'b1 || pat_addr !== 6'd0) begin
      bad++; $display("FAIL busy_hold got=run%b addr%0d want=run1 addr0", running, pat_addr);
    end
    busy_force = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (set_en) begin
        got = 1'b1;
        break;
      end
    end
    total++; if (!got) begin bad++; $display("FAIL busy_release_en got=0 want=1"); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (set_en !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl got=en%b run%b done%b want=000", set_en, running, done);
    end
    total++; if (set_central !== 24'd0 || set_radius !== 12'd0 || set_mode !== 2'd0 || pat_addr !== 6'd0) begin
      bad++; $display("FAIL midrst_bus got=%h/%h/%b/%0d want=0", set_central, set_radius, set_mode, pat_addr);
    end
    total++; if (err_cnt !== 7'd0 || aborted !== 1'b0 || pass !== 1'b0 || first_fail !== 6'd0) begin
      bad++; $display("FAIL midrst_status got=err%0d ab%b pass%b ff%0d want=0", err_cnt, aborted, pass, first_fail);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (running !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst got=run%b done%b want=00", running, done);
    end
    base = en_cnt;
    do_start(2'b11);
    total++; if (set_mode !== 2'b11 || pat_addr !== 6'd0) begin
      bad++; $display("FAIL restart got=mode%b addr%0d want=mode11 addr0", set_mode, pat_addr);
    end
    wait_done(2000, ok);
    total++; if (!ok || pass !== 1'b1 || en_cnt - base != 64) begin
      bad++; $display("FAIL restart_run got=ok%b pass%b n%0d want=ok1 pass1 n64", ok, pass, en_cnt - base);
    end
    total++; if (en_double != 0) begin bad++; $display("FAIL en_single_cycle got=%0d want=0", en_double); end
  endtask

  initial begin
    setup_rom(2'b00);
    test_reset();
    test_basic();
    test_mismatch();
    test_abort();
    test_timeout();
    test_busy_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
